// File: rtl/cmd_buffer_if.sv
// rtl/cmd_buffer_if.sv - slave-bus, execution-control and engine-stream signals of the command buffer
interface cmd_buffer_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int TRANS_ADDR_WIDTH = 8
);
    // Slave bus, decoded by the address decoder
    logic                        cmd_en;
    logic [TRANS_ADDR_WIDTH-1:0] trans_addr;
    logic                        slv_wr_en;
    logic [DATA_WIDTH-1:0]       slv_wr_data;
    logic                        slv_rd_en;
    logic [DATA_WIDTH-1:0]       slv_rd_data;
    logic                        slv_rd_valid;
    logic                        slv_err;

    // Execution control from / status to the register file
    logic                        start;
    logic                        abort;
    logic [TRANS_ADDR_WIDTH:0]   cmd_count;
    logic                        busy;
    logic                        done;
    logic                        cfg_err;

    // Command stream towards the engine
    logic                        eng_cmd_valid;
    logic [DATA_WIDTH-1:0]       eng_cmd_data;
    logic                        eng_cmd_ready;

    // Buffer side
    modport slave (
        input  cmd_en, trans_addr, slv_wr_en, slv_wr_data, slv_rd_en,
        input  start, abort, cmd_count, eng_cmd_ready,
        output slv_rd_data, slv_rd_valid, slv_err,
        output busy, done, cfg_err, eng_cmd_valid, eng_cmd_data
    );

    // Bus master / register file / engine side
    modport master (
        output cmd_en, trans_addr, slv_wr_en, slv_wr_data, slv_rd_en,
        output start, abort, cmd_count, eng_cmd_ready,
        input  slv_rd_data, slv_rd_valid, slv_err,
        input  busy, done, cfg_err, eng_cmd_valid, eng_cmd_data
    );
endinterface

// File: rtl/cmd_buffer.sv
// rtl/cmd_buffer.sv - command word store with slave access and sequential issue to the engine
module cmd_buffer #(
    parameter int DATA_WIDTH       = 32,
    parameter int TRANS_ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    cmd_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << TRANS_ADDR_WIDTH;
    // Largest legal count, expressed in the width of cmd_count
    localparam logic [TRANS_ADDR_WIDTH:0] MAX_COUNT = {1'b1, {TRANS_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [TRANS_ADDR_WIDTH-1:0] rd_ptr;
    logic [TRANS_ADDR_WIDTH-1:0] last_idx;

    logic count_ok;
    logic is_last;
    logic latch_count;
    logic ptr_step;
    logic fetch;
    logic cfg_bad;
    logic wr_fire;
    logic wr_reject;
    logic rd_fire;

    // Writes are only accepted while no execution is walking the array,
    // so the engine never sees a word change underneath it.
    assign wr_fire   = bus.cmd_en & bus.slv_wr_en & ~bus.busy;
    assign wr_reject = bus.cmd_en & bus.slv_wr_en &  bus.busy;
    assign rd_fire   = bus.cmd_en & bus.slv_rd_en;

    assign count_ok = (bus.cmd_count != '0) && (bus.cmd_count <= MAX_COUNT);
    // The pointer stops at last_idx, so a full-depth run ends at the top
    // index without ever wrapping to zero.
    assign is_last  = (rd_ptr == last_idx);

    assign bus.busy          = (state == FETCH) || (state == PRESENT);
    assign bus.done          = (state == DONE);
    assign bus.eng_cmd_valid = (state == PRESENT);

    // Array write port; contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[bus.trans_addr] <= bus.slv_wr_data;
        end
    end

    // Slave read port (latency 1, returns pre-write data on a same-cycle collision) and reject flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.slv_rd_data  <= '0;
            bus.slv_rd_valid <= 1'b0;
            bus.slv_err      <= 1'b0;
        end else begin
            bus.slv_rd_valid <= rd_fire;
            bus.slv_err      <= wr_reject;
            if (rd_fire) begin
                bus.slv_rd_data <= mem[bus.trans_addr];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control decode; abort outranks engine ready
    always_comb begin
        next_state  = state;
        latch_count = 1'b0;
        ptr_step    = 1'b0;
        fetch       = 1'b0;
        cfg_bad     = 1'b0;
        case (state)
            IDLE: begin
                // abort is meaningless here, so a coincident start still runs
                if (bus.start) begin
                    if (count_ok) begin
                        latch_count = 1'b1;
                        next_state  = FETCH;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else begin
                    fetch      = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (bus.eng_cmd_ready) begin
                    if (is_last) begin
                        next_state = DONE;
                    end else begin
                        ptr_step   = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Read pointer, latched last index, engine data register and config error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr           <= '0;
            last_idx         <= '0;
            bus.eng_cmd_data <= '0;
            bus.cfg_err      <= 1'b0;
        end else begin
            bus.cfg_err <= cfg_bad;
            if (latch_count) begin
                rd_ptr   <= '0;
                // Low bits minus one: a count of DEPTH maps onto the top index
                last_idx <= bus.cmd_count[TRANS_ADDR_WIDTH-1:0] - 1'b1;
            end else if (ptr_step) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fetch) begin
                bus.eng_cmd_data <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_cmd_buffer.sv
// tb/tb_cmd_buffer.sv - directed and randomized checks of cmd_buffer against a memory/queue model
module tb_cmd_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cmd_buffer_if #(.DATA_WIDTH(32), .TRANS_ADDR_WIDTH(8)) bus ();

    cmd_buffer #(.DATA_WIDTH(32), .TRANS_ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [256];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        bus.cmd_en      = 1'b1;
        bus.slv_wr_en   = 1'b1;
        bus.trans_addr  = 8'(addr);
        bus.slv_wr_data = data;
        step();
        bus.slv_wr_en   = 1'b0;
        bus.cmd_en      = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic rd(input int addr, input string tag);
        bus.cmd_en     = 1'b1;
        bus.slv_rd_en  = 1'b1;
        bus.trans_addr = 8'(addr);
        step();
        bus.slv_rd_en  = 1'b0;
        bus.cmd_en     = 1'b0;
        check({tag, "_valid"}, 64'(bus.slv_rd_valid), 64'd1);
        check({tag, "_data"}, 64'(bus.slv_rd_data), 64'(model_mem[addr]));
    endtask

    task automatic start_run(input int n, input string tag);
        bus.cmd_count = 9'(n);
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        check({tag, "_busy_on"}, 64'(bus.busy), 64'd1);
    endtask

    // Consume the issued stream; expected words are model_mem[0..n-1] in order.
    task automatic drain(input int n, input bit random_ready, input string tag, output int cycles);
        int idx   = 0;
        int dones = 0;
        cycles = 0;
        while (dones == 0 && cycles < 4000) begin
            bus.eng_cmd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.eng_cmd_valid) begin
                if (idx < n) begin
                    check({tag, "_word"}, 64'(bus.eng_cmd_data), 64'(model_mem[idx]));
                end else begin
                    check({tag, "_extra_word"}, 64'd1, 64'd0);
                end
                if (bus.eng_cmd_ready) idx++;
            end
            step();
            cycles++;
            if (bus.done) begin
                dones++;
                check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
            end
        end
        bus.eng_cmd_ready = 1'b0;
        check({tag, "_done_seen"}, 64'(dones), 64'd1);
        check({tag, "_word_count"}, 64'(idx), 64'(n));
        step();
        check({tag, "_done_single"}, 64'(bus.done), 64'd0);
        check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    // Run five words, stop on word index 2 with abort or reset, then prove recovery.
    task automatic cancel_test(input bit use_rst, input string tag);
        int idx = 0;
        int guard = 0;
        int cyc;
        for (int i = 0; i < 5; i++) wr(i, $urandom);
        start_run(5, tag);
        bus.eng_cmd_ready = 1'b1;
        while (!(bus.eng_cmd_valid && idx == 2) && guard < 50) begin
            if (bus.eng_cmd_valid) idx++;
            step();
            guard++;
        end
        check({tag, "_reached_word2"}, 64'(bus.eng_cmd_data), 64'(model_mem[2]));
        if (use_rst) rst = 1'b1;
        else bus.abort = 1'b1;
        step();
        rst = 1'b0;
        bus.abort = 1'b0;
        bus.eng_cmd_ready = 1'b0;
        check({tag, "_valid_off"}, 64'(bus.eng_cmd_valid), 64'd0);
        check({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_no_done"}, 64'(bus.done), 64'd0);
            step();
        end
        start_run(2, {tag, "_restart"});
        drain(2, 1'b0, {tag, "_restart"}, cyc);
    endtask

    initial begin
        int cyc;
        logic [31:0] old_val;

        bus.cmd_en = 0; bus.trans_addr = 0; bus.slv_wr_en = 0; bus.slv_wr_data = 0;
        bus.slv_rd_en = 0; bus.start = 0; bus.abort = 0; bus.cmd_count = 0;
        bus.eng_cmd_ready = 0;

        // Reset values
        step();
        step();
        check("rst_rd_data", 64'(bus.slv_rd_data), 64'd0);
        check("rst_rd_valid", 64'(bus.slv_rd_valid), 64'd0);
        check("rst_slv_err", 64'(bus.slv_err), 64'd0);
        check("rst_eng_valid", 64'(bus.eng_cmd_valid), 64'd0);
        check("rst_eng_data", 64'(bus.eng_cmd_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        rst = 1'b0;
        step();

        // Boundary offsets write/read
        wr(8'h00, 32'hA5A5_0001);
        wr(8'hFF, 32'hDEAD_BEEF);
        rd(8'h00, "rd_lo");
        rd(8'hFF, "rd_hi");
        step();
        check("rd_valid_pulse", 64'(bus.slv_rd_valid), 64'd0);

        // Random writes and readbacks
        for (int i = 0; i < 24; i++) wr(i, $urandom);
        for (int i = 0; i < 8; i++) rd($urandom_range(0, 23), "rd_rand");

        // Same-cycle read and write to one address returns the old word
        old_val = model_mem[5];
        bus.cmd_en = 1; bus.slv_wr_en = 1; bus.slv_rd_en = 1;
        bus.trans_addr = 8'd5; bus.slv_wr_data = 32'h1234_5678;
        step();
        bus.cmd_en = 0; bus.slv_wr_en = 0; bus.slv_rd_en = 0;
        check("raw_old_data", 64'(bus.slv_rd_data), 64'(old_val));
        model_mem[5] = 32'h1234_5678;
        rd(5, "raw_new_data");

        // Strobes without cmd_en do nothing
        bus.slv_wr_en = 1; bus.slv_rd_en = 1; bus.trans_addr = 8'd6; bus.slv_wr_data = 32'hFFFF_0000;
        step();
        bus.slv_wr_en = 0; bus.slv_rd_en = 0;
        check("noen_rd_valid", 64'(bus.slv_rd_valid), 64'd0);
        rd(6, "noen_unchanged");

        // Four words with ready held high: two cycles per word
        for (int i = 0; i < 4; i++) wr(i, $urandom);
        start_run(4, "run4");
        drain(4, 1'b0, "run4", cyc);
        check("run4_cycles", 64'(cyc), 64'd8);

        // Illegal counts
        bus.cmd_count = 9'd0; bus.start = 1;
        step();
        bus.start = 0;
        check("cnt0_busy", 64'(bus.busy), 64'd0);
        check("cnt0_cfg_err", 64'(bus.cfg_err), 64'd1);
        step();
        check("cnt0_cfg_pulse", 64'(bus.cfg_err), 64'd0);
        bus.cmd_count = 9'd257; bus.start = 1;
        step();
        bus.start = 0;
        check("cnt257_busy", 64'(bus.busy), 64'd0);
        check("cnt257_cfg_err", 64'(bus.cfg_err), 64'd1);
        step();
        check("cnt257_cfg_pulse", 64'(bus.cfg_err), 64'd0);

        // Write while busy is rejected; start while busy is ignored
        old_val = model_mem[16];
        start_run(3, "wbusy");
        step();
        bus.cmd_en = 1; bus.slv_wr_en = 1; bus.trans_addr = 8'h10; bus.slv_wr_data = ~old_val;
        step();
        bus.cmd_en = 0; bus.slv_wr_en = 0;
        check("wbusy_slv_err", 64'(bus.slv_err), 64'd1);
        step();
        check("wbusy_err_pulse", 64'(bus.slv_err), 64'd0);
        bus.cmd_count = 9'd0; bus.start = 1;
        step();
        bus.start = 0;
        step();
        check("start_busy_no_cfg", 64'(bus.cfg_err), 64'd0);
        rd(8'h10, "wbusy_old_val");
        drain(3, 1'b1, "wbusy", cyc);
        rd(8'h10, "wbusy_after");

        // Cancel mid-run by abort, then by reset
        cancel_test(1'b0, "abort");
        cancel_test(1'b1, "rst_mid");

        // Start coincident with abort in IDLE runs normally
        bus.abort = 1;
        start_run(1, "start_abort");
        bus.abort = 0;
        drain(1, 1'b0, "start_abort", cyc);

        // Full-depth run with random stalls
        for (int i = 0; i < 256; i++) wr(i, $urandom);
        start_run(256, "full");
        drain(256, 1'b1, "full", cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
